banked_btb: RTL

BANKED_BTB -- requirements
Module: banked_btb

---
 rtl/FetchUnitTypes.sv | 51 +++++
 rtl/banked_btb_bank.sv | 30 +++
 rtl/banked_btb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/FetchUnitTypes.sv
// Shared BTB types and PC field extraction helpers.
// Field widths here are upper bounds; banked_btb masks to its parameters.
package FetchUnitTypes;

  localparam int PC_WIDTH = 32;
  localparam int TAG_MAX  = 16;

  typedef struct packed {
    logic                valid;
    logic [TAG_MAX-1:0]  tag;
    logic [PC_WIDTH-1:0] target;
    logic                isCondBr;
  } btb_entry_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] addr;
    logic [PC_WIDTH-1:0] target;
    logic                isCondBr;
  } btb_qent_t;

  function automatic logic [PC_WIDTH-1:0] btbIndex(
    input logic [PC_WIDTH-1:0] addr,
    input int                  idxBits
  );
    logic [PC_WIDTH-1:0] m;
    m = (PC_WIDTH'(1) << idxBits) - PC_WIDTH'(1);
    return (addr >> 2) & m;
  endfunction

  function automatic logic [PC_WIDTH-1:0] btbBank(
    input logic [PC_WIDTH-1:0] index,
    input int                  bankBits
  );
    logic [PC_WIDTH-1:0] m;
    m = (PC_WIDTH'(1) << bankBits) - PC_WIDTH'(1);
    return index & m;
  endfunction

  function automatic logic [TAG_MAX-1:0] btbTag(
    input logic [PC_WIDTH-1:0] addr,
    input int                  idxBits,
    input int                  tagBits
  );
    logic [PC_WIDTH-1:0] m;
    logic [PC_WIDTH-1:0] t;
    m = (PC_WIDTH'(1) << tagBits) - PC_WIDTH'(1);
    t = (addr >> (idxBits + 2)) & m;
    return t[TAG_MAX-1:0];
  endfunction

endpackage

// File: rtl/banked_btb_bank.sv
// One BTB bank: single write port, READ_NUM registered read ports.
// Reads return the contents from before a same-edge write.
module banked_btb_bank
  import FetchUnitTypes::*;
#(
  parameter  int DEPTH    = 256,
  parameter  int READ_NUM = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                           clk_i,
  input  logic [READ_NUM-1:0][AW-1:0]    rdIdx_i,
  output btb_entry_t [READ_NUM-1:0]      rdData_o,
  input  logic                           wrEn_i,
  input  logic [AW-1:0]                  wrIdx_i,
  input  btb_entry_t                     wrData_i
);

  btb_entry_t                mem_q [DEPTH];
  btb_entry_t [READ_NUM-1:0] rd_q;

  always_ff @(posedge clk_i) begin
    if (wrEn_i) mem_q[wrIdx_i] <= wrData_i;
    for (int r = 0; r < READ_NUM; r++) begin
      rd_q[r] <= mem_q[rdIdx_i[r]];
    end
  end

  assign rdData_o = rd_q;

endmodule

// File: rtl/banked_btb.sv
// Banked branch target buffer with invalidate sweep and a
// conflict queue for updates that lose bank arbitration.
module banked_btb
  import FetchUnitTypes::*;
#(
  parameter int ENTRY_NUM   = 1024,
  parameter int BANK_NUM    = 4,
  parameter int READ_NUM    = 2,
  parameter int WRITE_NUM   = 2,
  parameter int QUEUE_DEPTH = 4,
  parameter int TAG_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] rdAddr     [READ_NUM],
  output logic                rdHit      [READ_NUM],
  output logic [PC_WIDTH-1:0] rdTarget   [READ_NUM],
  output logic                rdIsCondBr [READ_NUM],
  input  logic                wrValid    [WRITE_NUM],
  input  logic [PC_WIDTH-1:0] wrAddr     [WRITE_NUM],
  input  logic [PC_WIDTH-1:0] wrTarget   [WRITE_NUM],
  input  logic                wrIsCondBr [WRITE_NUM],
  output logic                busy,
  output logic [15:0]         dropCount
);

  localparam int IDX_W = $clog2(ENTRY_NUM);
  localparam int BNK_W = $clog2(BANK_NUM);
  localparam int DEPTH = ENTRY_NUM / BANK_NUM;
  localparam int ROW_W = IDX_W - BNK_W;
  localparam int QP_W  = $clog2(QUEUE_DEPTH);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [ROW_W-1:0] SW_ONE  = ROW_W'(1);
  localparam logic [ROW_W-1:0] SW_LAST = ROW_W'(DEPTH - 1);
  localparam logic [QP_W:0]    QP_ONE  = (QP_W + 1)'(1);
  localparam logic [QP_W:0]    QP_FULL = (QP_W + 1)'(QUEUE_DEPTH);

  logic [0:0]       state_q, state_d;
  logic [ROW_W-1:0] sweep_q, sweep_d;
  logic [QP_W:0]    wPtr_q, wPtr_d;
  logic [QP_W:0]    rPtr_q, rPtr_d;
  logic [15:0]      drop_q, drop_d;
  btb_qent_t        qMem_q [QUEUE_DEPTH];

  logic                               rdEn_q;
  logic [READ_NUM-1:0][BNK_W-1:0]     rdBank_q;
  logic [READ_NUM-1:0][TAG_MAX-1:0]   rdTag_q;
  logic [READ_NUM-1:0][ROW_W-1:0]     rowIdx;
  btb_entry_t [READ_NUM-1:0]          bkRd [BANK_NUM];
  btb_entry_t                         rdE  [READ_NUM];

  logic                  bkWrEn   [BANK_NUM];
  logic [ROW_W-1:0]      bkWrIdx  [BANK_NUM];
  btb_entry_t            bkWrData [BANK_NUM];

  logic [IDX_W-1:0]      wIdx    [WRITE_NUM];
  logic [WRITE_NUM-1:0]  survive;
  logic                  enqEn   [WRITE_NUM];
  logic [QP_W-1:0]       enqSlot [WRITE_NUM];

  logic [BANK_NUM-1:0]   bankBusy;
  logic [IDX_W-1:0]      ix;
  logic [BNK_W-1:0]      bk;
  logic [QP_W:0]         free;
  logic [7:0]            nDrop;
  logic [16:0]           dsum;
  btb_qent_t             head;

  function automatic btb_entry_t mkEnt(
    input logic [PC_WIDTH-1:0] a,
    input logic [PC_WIDTH-1:0] t,
    input logic                c
  );
    btb_entry_t e;
    e.valid    = 1'b1;
    e.tag      = btbTag(a, IDX_W, TAG_WIDTH);
    e.target   = t;
    e.isCondBr = c;
    return e;
  endfunction

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    banked_btb_bank #(
      .DEPTH    (DEPTH),
      .READ_NUM (READ_NUM)
    ) u_bank (
      .clk_i    (clk),
      .rdIdx_i  (rowIdx),
      .rdData_o (bkRd[b]),
      .wrEn_i   (bkWrEn[b]),
      .wrIdx_i  (bkWrIdx[b]),
      .wrData_i (bkWrData[b])
    );
  end

  always_comb begin
    for (int r = 0; r < READ_NUM; r++) begin
      rowIdx[r] = ROW_W'(btbIndex(rdAddr[r], IDX_W) >> BNK_W);
      rdE[r]        = bkRd[rdBank_q[r]][r];
      rdHit[r]      = rdEn_q && rdE[r].valid && (rdE[r].tag == rdTag_q[r]);
      rdTarget[r]   = rdE[r].target;
      rdIsCondBr[r] = rdE[r].isCondBr;
    end
  end

  // Youngest port wins when two updates target the same index.
  always_comb begin
    for (int p = 0; p < WRITE_NUM; p++) begin
      wIdx[p]    = IDX_W'(btbIndex(wrAddr[p], IDX_W));
      survive[p] = wrValid[p];
    end
    for (int p = 0; p < WRITE_NUM; p++) begin
      for (int q = p + 1; q < WRITE_NUM; q++) begin
        if (wrValid[q] && (wIdx[q] == wIdx[p])) survive[p] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    wPtr_d   = wPtr_q;
    rPtr_d   = rPtr_q;
    drop_d   = drop_q;
    bankBusy = '0;
    nDrop    = '0;
    ix       = '0;
    bk       = '0;
    dsum     = '0;
    free     = QP_FULL - (wPtr_q - rPtr_q);
    head     = qMem_q[rPtr_q[QP_W-1:0]];
    for (int p = 0; p < WRITE_NUM; p++) begin
      enqEn[p]   = 1'b0;
      enqSlot[p] = '0;
    end
    for (int b = 0; b < BANK_NUM; b++) begin
      bkWrEn[b]   = 1'b0;
      bkWrIdx[b]  = sweep_q;
      bkWrData[b] = '0;
    end
    unique case (1'b1)
      (state_q == ST_INIT): begin
        for (int b = 0; b < BANK_NUM; b++) bkWrEn[b] = 1'b1;
        wPtr_d = '0;
        rPtr_d = '0;
        if (flush) begin
          sweep_d = '0;
        end else if (sweep_q == SW_LAST) begin
          state_d = ST_RUN;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + SW_ONE;
        end
      end
      (state_q == ST_RUN && flush): begin
        state_d = ST_INIT;
        sweep_d = '0;
        wPtr_d  = '0;
        rPtr_d  = '0;
      end
      default: begin
        // Head has top priority, so a non-empty queue always pops.
        if (wPtr_q != rPtr_q) begin
          ix = IDX_W'(btbIndex(head.addr, IDX_W));
          bk = ix[BNK_W-1:0];
          bankBusy[bk] = 1'b1;
          bkWrEn[bk]   = 1'b1;
          bkWrIdx[bk]  = ix[IDX_W-1:BNK_W];
          bkWrData[bk] = mkEnt(head.addr, head.target, head.isCondBr);
          rPtr_d = rPtr_q + QP_ONE;
          free   = free + QP_ONE;
        end
        for (int p = 0; p < WRITE_NUM; p++) begin
          if (survive[p]) begin
            ix = wIdx[p];
            bk = ix[BNK_W-1:0];
            if (!bankBusy[bk]) begin
              bankBusy[bk] = 1'b1;
              bkWrEn[bk]   = 1'b1;
              bkWrIdx[bk]  = ix[IDX_W-1:BNK_W];
              bkWrData[bk] = mkEnt(wrAddr[p], wrTarget[p], wrIsCondBr[p]);
            end else if (free != '0) begin
              enqEn[p]   = 1'b1;
              enqSlot[p] = wPtr_d[QP_W-1:0];
              wPtr_d     = wPtr_d + QP_ONE;
              free       = free - QP_ONE;
            end else begin
              nDrop = nDrop + 8'd1;
            end
          end
        end
        dsum   = {1'b0, drop_q} + {9'b0, nDrop};
        drop_d = dsum[16] ? 16'hFFFF : dsum[15:0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= ST_INIT;
      sweep_q  <= '0;
      wPtr_q   <= '0;
      rPtr_q   <= '0;
      drop_q   <= '0;
      rdEn_q   <= 1'b0;
      rdBank_q <= '0;
      rdTag_q  <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      wPtr_q  <= wPtr_d;
      rPtr_q  <= rPtr_d;
      drop_q  <= drop_d;
      rdEn_q  <= (state_q == ST_RUN);
      for (int r = 0; r < READ_NUM; r++) begin
        rdBank_q[r] <= BNK_W'(btbBank(btbIndex(rdAddr[r], IDX_W), BNK_W));
        rdTag_q[r]  <= btbTag(rdAddr[r], IDX_W, TAG_WIDTH);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < WRITE_NUM; p++) begin
      if (enqEn[p]) begin
        qMem_q[enqSlot[p]] <= {wrAddr[p], wrTarget[p], wrIsCondBr[p]};
      end
    end
  end

  assign busy      = (state_q == ST_INIT);
  assign dropCount = drop_q;

endmodule
